// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
package pc_seq_pkg;

    localparam int ADDR_W = 16;

    // Instruction phase of the sequencer.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Source of the next PC value.
    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        SEQ   = 3'd1,
        TGT   = 3'd2,
        POP   = 3'd3,
        VEC   = 3'd4,
        BOOTV = 3'd5
    } sel_t;

    // Return-stack entry: isr marks entries pushed by interrupt entry.
    typedef struct packed {
        logic              isr;
        logic [ADDR_W-1:0] addr;
    } rs_entry_t;

    // Sequential successor, wraps modulo 2^16 with no flag.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Small LIFO of return addresses. A push when full is dropped and a pop
// when empty does nothing; the caller reads full/empty to flag the error.
// The caller never requests push and pop in the same cycle.
module return_stack
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  rs_entry_t push_data,
    output rs_entry_t top_data,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [PW:0] count;
    logic [PW:0] top_idx;
    rs_entry_t   mem [DEPTH];

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign top_idx = count - 1'b1;

    // Top-of-stack read; zero when empty so nothing undefined leaks out.
    always_comb begin
        top_data = '0;
        if (!empty) begin
            top_data = mem[top_idx[PW-1:0]];
        end
    end

    // Occupancy counter; reset empties the stack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    // Entry storage; only the slot just above the current top is written.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: walks each instruction through FETCH and EXEC,
// picks the next PC source by priority and owns the return stack,
// the interrupt mask and the sticky stack-error flag.
//
// Fetch handshake: imem_req is high for every FETCH cycle and requests
// the word at PC; the word transfers on a cycle where imem_req and
// imem_ack are both high, and imem_req drops the following cycle.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BOOT_ADDR = 16'h0000,
    parameter logic [ADDR_W-1:0] IRQ_VEC   = 16'h0010,
    parameter int                RS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              PC_rst,
    input  logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_next,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic              exec_done,
    input  logic              br_taken,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    input  logic              halt,
    input  logic              irq,
    output logic              irq_en,
    output logic              rs_err,
    output state_t            state_dbg
);

    state_t            state, state_n;
    sel_t              sel;
    logic              irq_en_n;
    logic              err_set;
    logic              rs_push, rs_pop;
    rs_entry_t         push_data;
    rs_entry_t         top_data;
    logic              rs_full, rs_empty;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc    = addr_inc(PC);
    assign state_dbg = state;

    return_stack #(
        .DEPTH (RS_DEPTH)
    ) u_rs (
        .clk       (clk),
        .rst       (PC_rst),
        .push      (rs_push),
        .pop       (rs_pop),
        .push_data (push_data),
        .top_data  (top_data),
        .full      (rs_full),
        .empty     (rs_empty)
    );

    // State, interrupt mask and sticky error all move on the PC edge.
    always_ff @(posedge clk or posedge PC_rst) begin
        if (PC_rst) begin
            state  <= BOOT;
            irq_en <= 1'b1;
            rs_err <= 1'b0;
        end else begin
            state  <= state_n;
            irq_en <= irq_en_n;
            if (err_set) begin
                rs_err <= 1'b1;
            end
        end
    end

    // Next state, redirect select and stack control, first match wins in EXEC.
    always_comb begin
        state_n   = state;
        sel       = HOLD;
        imem_req  = 1'b0;
        rs_push   = 1'b0;
        rs_pop    = 1'b0;
        push_data = '{isr: 1'b0, addr: pc_inc};
        irq_en_n  = irq_en;
        err_set   = 1'b0;
        case (state)
            BOOT: begin
                sel     = BOOTV;
                state_n = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    state_n = FETCH;
                    if (irq && irq_en) begin
                        rs_push   = 1'b1;
                        push_data = '{isr: 1'b1, addr: pc_inc};
                        err_set   = rs_full;
                        sel       = VEC;
                        irq_en_n  = 1'b0;
                    end else if (ret) begin
                        if (rs_empty) begin
                            // Underflow: fall through to the next instruction.
                            sel     = SEQ;
                            err_set = 1'b1;
                        end else begin
                            rs_pop = 1'b1;
                            sel    = POP;
                            if (top_data.isr) begin
                                irq_en_n = 1'b1;
                            end
                        end
                    end else if (call) begin
                        rs_push   = 1'b1;
                        push_data = '{isr: 1'b0, addr: pc_inc};
                        err_set   = rs_full;
                        sel       = TGT;
                    end else if (jump || br_taken) begin
                        sel = TGT;
                    end else if (halt) begin
                        sel     = SEQ;
                        state_n = HALT;
                    end else begin
                        sel = SEQ;
                    end
                end
            end
            HALT: begin
                if (irq && irq_en) begin
                    // Halted PC already points past the halt; resume there.
                    rs_push   = 1'b1;
                    push_data = '{isr: 1'b1, addr: PC};
                    err_set   = rs_full;
                    sel       = VEC;
                    irq_en_n  = 1'b0;
                    state_n   = FETCH;
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    // Next-PC source mux.
    always_comb begin
        PC_next = PC;
        case (sel)
            HOLD:    PC_next = PC;
            SEQ:     PC_next = pc_inc;
            TGT:     PC_next = target;
            POP:     PC_next = top_data.addr;
            VEC:     PC_next = IRQ_VEC;
            BOOTV:   PC_next = BOOT_ADDR;
            default: PC_next = PC;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a directed per-cycle vector table walking a
// long instruction stream, then hand-written overflow and reset sequences.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk;
    logic        PC_rst;
    logic [15:0] PC;
    logic [15:0] PC_next;
    logic        imem_req;
    logic        imem_ack;
    logic        exec_done;
    logic        br_taken;
    logic        jump;
    logic        call;
    logic        ret;
    logic [15:0] target;
    logic        halt;
    logic        irq;
    logic        irq_en;
    logic        rs_err;
    state_t      state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic        ack, done, br, jmp, cl, rt, hl, iq;
        logic [15:0] tgt, pc, nxt;
        logic        req, ien, err;
        state_t      st;
    } vec_t;

    vec_t vecs[$];

    pc_sequencer #(
        .BOOT_ADDR (16'h0100),
        .IRQ_VEC   (16'h0010),
        .RS_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .PC_rst    (PC_rst),
        .PC        (PC),
        .PC_next   (PC_next),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .exec_done (exec_done),
        .br_taken  (br_taken),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .target    (target),
        .halt      (halt),
        .irq       (irq),
        .irq_en    (irq_en),
        .rs_err    (rs_err),
        .state_dbg (state_dbg)
    );

    // Clock and the PC register the sequencer feeds.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge PC_rst) begin
        if (PC_rst) PC <= 16'h0000;
        else        PC <= PC_next;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        br_taken  = 1'b0;
        jump      = 1'b0;
        call      = 1'b0;
        ret       = 1'b0;
        halt      = 1'b0;
        irq       = 1'b0;
        target    = 16'h0000;
    endtask

    task automatic add(input logic ack, done, br, jmp, cl, rt, hl, iq,
                       input logic [15:0] tgt, pc, nxt,
                       input logic req, ien, err, input state_t st);
        vec_t v;
        v.ack = ack; v.done = done; v.br = br; v.jmp = jmp;
        v.cl = cl; v.rt = rt; v.hl = hl; v.iq = iq;
        v.tgt = tgt; v.pc = pc; v.nxt = nxt;
        v.req = req; v.ien = ien; v.err = err; v.st = st;
        vecs.push_back(v);
    endtask

    // One full instruction: FETCH with immediate ack, EXEC with immediate done.
    task automatic run_instr(input logic cl, rt, jp, input logic [15:0] tgt,
                             input logic [15:0] exp_nxt, input string name);
        @(negedge clk);
        clear_inputs();
        imem_ack = 1'b1;
        #1 chk({name, " req"}, 32'(imem_req), 32'd1);
        @(negedge clk);
        imem_ack  = 1'b0;
        exec_done = 1'b1;
        call      = cl;
        ret       = rt;
        jump      = jp;
        target    = tgt;
        #1 chk({name, " pc_next"}, 32'(PC_next), 32'(exp_nxt));
    endtask

    initial begin
        logic [15:0] pc_m;
        logic [15:0] tgt_m;
        logic [15:0] e;

        // ack done br jmp call ret halt irq | target pc pc_next | req ien err state
        add(0,0,0,0,0,0,0,0, 16'h0000, 16'h0000, 16'h0100, 0,1,0, BOOT);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0100, 16'h0100, 1,1,0, FETCH);
        add(0,1,0,0,0,0,0,0, 16'h0000, 16'h0100, 16'h0101, 0,1,0, EXEC);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0101, 16'h0101, 1,1,0, FETCH);
        add(0,1,0,0,0,0,0,0, 16'h0000, 16'h0101, 16'h0102, 0,1,0, EXEC);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0102, 16'h0102, 1,1,0, FETCH);
        add(0,1,0,0,0,0,0,0, 16'h0000, 16'h0102, 16'h0103, 0,1,0, EXEC);
        add(0,0,0,0,0,0,0,0, 16'h0000, 16'h0103, 16'h0103, 1,1,0, FETCH);
        add(0,0,0,0,0,0,0,0, 16'h0000, 16'h0103, 16'h0103, 1,1,0, FETCH);
        add(0,0,0,0,0,0,0,0, 16'h0000, 16'h0103, 16'h0103, 1,1,0, FETCH);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0103, 16'h0103, 1,1,0, FETCH);
        add(0,0,0,1,0,0,0,0, 16'h0200, 16'h0103, 16'h0103, 0,1,0, EXEC);
        add(0,1,0,1,0,0,0,0, 16'h0200, 16'h0103, 16'h0200, 0,1,0, EXEC);
        add(1,0,0,0,1,0,0,0, 16'h0999, 16'h0200, 16'h0200, 1,1,0, FETCH);
        add(0,1,1,0,1,0,0,0, 16'h0300, 16'h0200, 16'h0300, 0,1,0, EXEC);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0300, 16'h0300, 1,1,0, FETCH);
        add(0,1,0,0,0,1,0,0, 16'h0000, 16'h0300, 16'h0201, 0,1,0, EXEC);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0201, 16'h0201, 1,1,0, FETCH);
        add(0,1,0,1,0,0,0,0, 16'h0050, 16'h0201, 16'h0050, 0,1,0, EXEC);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0050, 16'h0050, 1,1,0, FETCH);
        add(0,1,0,0,0,0,0,1, 16'h0000, 16'h0050, 16'h0010, 0,1,0, EXEC);
        add(1,0,0,0,0,0,0,1, 16'h0000, 16'h0010, 16'h0010, 1,0,0, FETCH);
        add(0,1,0,0,0,0,0,1, 16'h0000, 16'h0010, 16'h0011, 0,0,0, EXEC);
        add(1,0,0,0,0,0,0,1, 16'h0000, 16'h0011, 16'h0011, 1,0,0, FETCH);
        add(0,1,0,0,0,1,0,1, 16'h0000, 16'h0011, 16'h0051, 0,0,0, EXEC);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0051, 16'h0051, 1,1,0, FETCH);
        add(0,1,0,0,0,1,0,0, 16'h0000, 16'h0051, 16'h0052, 0,1,0, EXEC);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0052, 16'h0052, 1,1,1, FETCH);
        add(0,1,0,1,0,0,0,0, 16'h0400, 16'h0052, 16'h0400, 0,1,1, EXEC);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0400, 16'h0400, 1,1,1, FETCH);
        add(0,1,0,0,0,0,1,0, 16'h0000, 16'h0400, 16'h0401, 0,1,1, EXEC);
        add(0,1,0,1,0,0,0,0, 16'h0777, 16'h0401, 16'h0401, 0,1,1, HALT);
        for (int k = 0; k < 4; k++) begin
            add(0,0,0,0,0,0,0,0, 16'h0000, 16'h0401, 16'h0401, 0,1,1, HALT);
        end
        add(0,0,0,0,0,0,0,1, 16'h0000, 16'h0401, 16'h0010, 0,1,1, HALT);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0010, 16'h0010, 1,0,1, FETCH);
        add(0,1,0,0,0,1,0,0, 16'h0000, 16'h0010, 16'h0401, 0,0,1, EXEC);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'h0401, 16'h0401, 1,1,1, FETCH);
        add(0,1,0,1,0,0,0,0, 16'hFFFF, 16'h0401, 16'hFFFF, 0,1,1, EXEC);
        add(1,0,0,0,0,0,0,0, 16'h0000, 16'hFFFF, 16'hFFFF, 1,1,1, FETCH);
        add(0,1,0,0,0,0,0,0, 16'h0000, 16'hFFFF, 16'h0000, 0,1,1, EXEC);
        add(0,0,0,0,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 1,1,1, FETCH);

        // Reset block.
        clear_inputs();
        PC_rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset pc_next",  32'(PC_next),   32'h0100);
        chk("reset imem_req", 32'(imem_req),  32'd0);
        chk("reset irq_en",   32'(irq_en),    32'd1);
        chk("reset rs_err",   32'(rs_err),    32'd0);
        chk("reset state",    32'(state_dbg), 32'(BOOT));

        // Table-driven instruction stream.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (i == 0) PC_rst = 1'b0;
            imem_ack  = vecs[i].ack;
            exec_done = vecs[i].done;
            br_taken  = vecs[i].br;
            jump      = vecs[i].jmp;
            call      = vecs[i].cl;
            ret       = vecs[i].rt;
            halt      = vecs[i].hl;
            irq       = vecs[i].iq;
            target    = vecs[i].tgt;
            #1;
            chk($sformatf("row%0d pc", i),       32'(PC),        32'(vecs[i].pc));
            chk($sformatf("row%0d pc_next", i),  32'(PC_next),   32'(vecs[i].nxt));
            chk($sformatf("row%0d imem_req", i), 32'(imem_req),  32'(vecs[i].req));
            chk($sformatf("row%0d irq_en", i),   32'(irq_en),    32'(vecs[i].ien));
            chk($sformatf("row%0d rs_err", i),   32'(rs_err),    32'(vecs[i].err));
            chk($sformatf("row%0d state", i),    32'(state_dbg), 32'(vecs[i].st));
        end

        // Fresh reset, then RS_DEPTH+1 nested calls.
        @(negedge clk);
        clear_inputs();
        PC_rst = 1'b1;
        @(negedge clk);
        #1 chk("reset2 rs_err", 32'(rs_err), 32'd0);
        PC_rst = 1'b0;
        pc_m = 16'h0100;
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                @(negedge clk);
                clear_inputs();
                #1 chk("rs_err before overflow", 32'(rs_err), 32'd0);
            end
            tgt_m = 16'h0A00 + 16'(k * 16'h0100);
            if (exp_q.size() < 4) exp_q.push_back(pc_m + 16'd1);
            run_instr(1'b1, 1'b0, 1'b0, tgt_m, tgt_m, $sformatf("call%0d", k));
            pc_m = tgt_m;
        end
        @(negedge clk);
        clear_inputs();
        #1 chk("rs_err after overflow", 32'(rs_err), 32'd1);
        for (int j = 0; j < 4; j++) begin
            e = exp_q.pop_back();
            run_instr(1'b0, 1'b1, 1'b0, 16'h0000, e, $sformatf("pop%0d", j));
            pc_m = e;
        end
        run_instr(1'b0, 1'b1, 1'b0, 16'h0000, pc_m + 16'd1, "pop empty");

        // Reset asserted in the middle of a FETCH with an ack arriving.
        @(negedge clk);
        clear_inputs();
        #1 chk("midfetch req before", 32'(imem_req), 32'd1);
        #2;
        imem_ack = 1'b1;
        PC_rst   = 1'b1;
        #1;
        chk("midfetch req drop", 32'(imem_req),  32'd0);
        chk("midfetch pc_next",  32'(PC_next),   32'h0100);
        chk("midfetch state",    32'(state_dbg), 32'(BOOT));
        @(negedge clk);
        #1 chk("midfetch ack ignored", 32'(state_dbg), 32'(BOOT));
        imem_ack = 1'b0;
        PC_rst   = 1'b0;
        #1 chk("midfetch rs_err clr", 32'(rs_err), 32'd0);
        run_instr(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0101, "post reset pop empty");
        @(negedge clk);
        clear_inputs();
        #1 chk("post reset rs_err", 32'(rs_err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
